// File: rtl/rat_pkg.sv
// Shared defaults and helpers for the N-way register alias table.
// Lane slicing and reset-map helpers used by rat_nway and kth_free_sel.
package rat_pkg;

  localparam int WIDTH_D    = 2;
  localparam int ARCH_IDX_D = 5;
  localparam int PRF_IDX_D  = 6;
  localparam int PRF_SZ_D   = 64;

  // Low bit of lane k in a flattened per-lane bus of w-bit fields.
  function automatic int lane_lo(input int k, input int w);
    return k * w;
  endfunction

  // Reset free-list map: physical regs above the arch identity map are free.
  function automatic logic rst_free(input int i, input int arch_sz);
    return i >= arch_sz;
  endfunction

endpackage

// File: rtl/kth_free_sel.sv
// Picks, for each active lane in order, the next lowest free physical reg.
// Returns one-hot grants and the encoded index per lane.
module kth_free_sel
  import rat_pkg::*;
#(
  parameter int WIDTH   = WIDTH_D,
  parameter int PRF_IDX = PRF_IDX_D,
  parameter int PRF_SZ  = PRF_SZ_D
) (
  input  logic [PRF_SZ-1:0]              fl,
  input  logic [WIDTH-1:0]               issue,
  output logic [WIDTH-1:0][PRF_SZ-1:0]   grant,
  output logic [WIDTH-1:0][PRF_IDX-1:0]  idx
);

  logic [PRF_SZ-1:0] avail;
  logic              found;

  always_comb begin
    avail = fl;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < WIDTH; k++) begin
      found = 1'b0;
      if (issue[k]) begin
        for (int i = 0; i < PRF_SZ; i++) begin
          if (!found && avail[i]) begin
            found       = 1'b1;
            grant[k][i] = 1'b1;
            idx[k]      = PRF_IDX'(i);
            avail[i]    = 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: rtl/rat_nway.sv
// N-way rename table with speculative/retired maps and free lists.
// Renames and retires up to WIDTH lanes per cycle; flush restores retired state.
module rat_nway
  import rat_pkg::*;
#(
  parameter int WIDTH    = WIDTH_D,
  parameter int ARCH_IDX = ARCH_IDX_D,
  parameter int PRF_IDX  = PRF_IDX_D,
  parameter int PRF_SZ   = PRF_SZ_D
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  input  logic [WIDTH-1:0]            issue,
  input  logic [WIDTH*ARCH_IDX-1:0]   rega_idx_in,
  input  logic [WIDTH*ARCH_IDX-1:0]   regb_idx_in,
  input  logic [WIDTH*ARCH_IDX-1:0]   dest_idx_in,
  output logic [WIDTH*PRF_IDX-1:0]    prega_idx_out,
  output logic [WIDTH*PRF_IDX-1:0]    pregb_idx_out,
  output logic [WIDTH*PRF_IDX-1:0]    pdest_idx_out,
  output logic [WIDTH*PRF_IDX-1:0]    pdest_old_out,
  output logic                        rename_ready,
  output logic [PRF_IDX:0]            free_count,
  input  logic [WIDTH-1:0]            commit,
  input  logic [WIDTH*ARCH_IDX-1:0]   retire_dest_idx_in,
  input  logic [WIDTH*PRF_IDX-1:0]    retire_pdest_idx_in
);

  localparam int ARCH_SZ = 1 << ARCH_IDX;

  typedef logic [PRF_IDX-1:0]  preg_t;
  typedef logic [ARCH_IDX-1:0] areg_t;

  preg_t             rat    [ARCH_SZ];
  preg_t             rrat   [ARCH_SZ];
  preg_t             rat_n  [ARCH_SZ];
  preg_t             rrat_n [ARCH_SZ];
  logic [PRF_SZ-1:0] fl, rfl, fl_n, rfl_n, frees;
  logic [PRF_IDX:0]  cnt, cnt_n;

  areg_t ra [WIDTH];
  areg_t rb [WIDTH];
  areg_t rd [WIDTH];
  areg_t cd [WIDTH];
  preg_t cp [WIDTH];
  preg_t pa [WIDTH];
  preg_t pb [WIDTH];
  preg_t po [WIDTH];
  preg_t fr;

  logic [WIDTH-1:0][PRF_SZ-1:0]  grant;
  logic [WIDTH-1:0][PRF_IDX-1:0] alloc;
  logic                          accept;
  logic [WIDTH-1:0]              act;

  always_comb begin
    for (int k = 0; k < WIDTH; k++) begin
      ra[k] = rega_idx_in[lane_lo(k, ARCH_IDX) +: ARCH_IDX];
      rb[k] = regb_idx_in[lane_lo(k, ARCH_IDX) +: ARCH_IDX];
      rd[k] = dest_idx_in[lane_lo(k, ARCH_IDX) +: ARCH_IDX];
      cd[k] = retire_dest_idx_in[lane_lo(k, ARCH_IDX) +: ARCH_IDX];
      cp[k] = retire_pdest_idx_in[lane_lo(k, PRF_IDX) +: PRF_IDX];
    end
  end

  kth_free_sel #(
    .WIDTH   (WIDTH),
    .PRF_IDX (PRF_IDX),
    .PRF_SZ  (PRF_SZ)
  ) u_sel (
    .fl    (fl),
    .issue (issue),
    .grant (grant),
    .idx   (alloc)
  );

  assign rename_ready = cnt >= (PRF_IDX+1)'(WIDTH);
  assign free_count   = cnt;
  assign accept       = rename_ready & ~flush;
  assign act          = issue & {WIDTH{accept}};

  // RAT read, then younger lanes see the newest older-lane producer.
  always_comb begin
    for (int k = 0; k < WIDTH; k++) begin
      pa[k] = rat[ra[k]];
      pb[k] = rat[rb[k]];
      po[k] = rat[rd[k]];
      for (int j = 0; j < k; j++) begin
        if (issue[j] && rd[j] == ra[k]) pa[k] = alloc[j];
        if (issue[j] && rd[j] == rb[k]) pb[k] = alloc[j];
        if (issue[j] && rd[j] == rd[k]) po[k] = alloc[j];
      end
    end
  end

  always_comb begin
    prega_idx_out = '0;
    pregb_idx_out = '0;
    pdest_idx_out = '0;
    pdest_old_out = '0;
    for (int k = 0; k < WIDTH; k++) begin
      prega_idx_out[lane_lo(k, PRF_IDX) +: PRF_IDX] = pa[k];
      pregb_idx_out[lane_lo(k, PRF_IDX) +: PRF_IDX] = pb[k];
      pdest_idx_out[lane_lo(k, PRF_IDX) +: PRF_IDX] = alloc[k];
      pdest_old_out[lane_lo(k, PRF_IDX) +: PRF_IDX] = po[k];
    end
  end

  // Retire in lane order so a later lane frees what an earlier one mapped.
  always_comb begin
    rrat_n = rrat;
    rfl_n  = rfl;
    frees  = '0;
    fr     = '0;
    for (int k = 0; k < WIDTH; k++) begin
      if (commit[k]) begin
        fr             = rrat_n[cd[k]];
        rfl_n[fr]      = 1'b1;
        frees[fr]      = 1'b1;
        rfl_n[cp[k]]   = 1'b0;
        rrat_n[cd[k]]  = cp[k];
      end
    end
  end

  always_comb begin
    rat_n = rat;
    fl_n  = fl;
    cnt_n = '0;
    if (flush) begin
      rat_n = rrat_n;
      fl_n  = rfl_n;
    end else begin
      for (int k = 0; k < WIDTH; k++) begin
        if (act[k]) begin
          rat_n[rd[k]] = alloc[k];
          fl_n         = fl_n & ~grant[k];
        end
      end
      fl_n = fl_n | frees;
    end
    for (int i = 0; i < PRF_SZ; i++) begin
      cnt_n = cnt_n + (PRF_IDX+1)'(fl_n[i]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ARCH_SZ; i++) begin
        rat[i]  <= preg_t'(i);
        rrat[i] <= preg_t'(i);
      end
      for (int i = 0; i < PRF_SZ; i++) begin
        fl[i]  <= rst_free(i, ARCH_SZ);
        rfl[i] <= rst_free(i, ARCH_SZ);
      end
      cnt <= (PRF_IDX+1)'(PRF_SZ - ARCH_SZ);
    end else begin
      rat  <= rat_n;
      rrat <= rrat_n;
      fl   <= fl_n;
      rfl  <= rfl_n;
      cnt  <= cnt_n;
    end
  end

endmodule

// File: doc/rat_nway.md
Name: rat_nway

Overview:
- Parametrised N-way register alias table with integrated free list and retirement RAT (RRAT).
- Renames up to WIDTH instructions per cycle, with intra-group dependency bypass.
- Frees superseded physical registers at commit and restores speculative state on flush.
- Sits between decode and the RS/ROB dispatch stage; generalises the fixed 2-way rename table to arbitrary width and PRF size.

Parameters:
- WIDTH, 2, rename/commit lanes per cycle (1..4).
- ARCH_IDX, 5, architectural register index width; ARCH_SZ = 1<<ARCH_IDX.
- PRF_IDX, 6, physical register index width.
- PRF_SZ, 64, physical register count; must satisfy ARCH_SZ + WIDTH <= PRF_SZ <= 1<<PRF_IDX.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- flush  in  1  mispredict/exception recovery: restore RAT and free list from retired state
- issue  in  WIDTH  per-lane rename request; lanes are contiguous from lane 0
- rega_idx_in  in  WIDTH*ARCH_IDX  source A arch index per lane
- regb_idx_in  in  WIDTH*ARCH_IDX  source B arch index per lane
- dest_idx_in  in  WIDTH*ARCH_IDX  destination arch index per lane
- prega_idx_out  out  WIDTH*PRF_IDX  renamed source A
- pregb_idx_out  out  WIDTH*PRF_IDX  renamed source B
- pdest_idx_out  out  WIDTH*PRF_IDX  newly allocated physical destination
- pdest_old_out  out  WIDTH*PRF_IDX  previous speculative mapping of dest (for ROB)
- rename_ready  out  1  free list holds at least WIDTH entries
- free_count  out  PRF_IDX+1  number of entries in the speculative free list
- commit  in  WIDTH  per-lane retire; lanes contiguous, in program order
- retire_dest_idx_in  in  WIDTH*ARCH_IDX  retiring arch dest
- retire_pdest_idx_in  in  WIDTH*PRF_IDX  retiring physical dest

Behaviour:
- Reset (async):
  - RAT[i] = RRAT[i] = i for i < ARCH_SZ.
  - fl = rfl = 1 for PRF entries ARCH_SZ..PRF_SZ-1, 0 below.
  - free_count = PRF_SZ-ARCH_SZ; rename_ready = 1.
- Rename (combinational, zero latency; state updates at posedge):
  - Lane k allocates the k-th lowest set bit of the registered fl, counting only active lanes.
  - Sources read the RAT, then bypass: if lane j<k has issue[j] and dest_idx[j] matches, take pdest[j] of the highest such j.
  - pdest_old_out uses the same bypass on the dest index.
- Handshake:
  - issue is accepted only when rename_ready=1 and flush=0; otherwise it is ignored and no state changes.
  - Outputs are don't-care for lanes with issue=0.
- On an accepted issue: RAT[dest_k] <= pdest_k (highest lane wins on equal dest) and fl[pdest_k] <= 0.
- Commit:
  - RRAT updated in lane order; freed reg = RRAT[retire_dest_k], bypassed by an earlier committing lane with the same arch dest.
  - rfl[freed] <= 1, fl[freed] <= 1, rfl[retire_pdest_k] <= 0.
  - Commit is processed identically during flush.
- Simultaneous issue and commit: freed regs are not allocatable in the same cycle; they become visible next cycle. Setting and clearing the same bit cannot collide, because freed regs are never in the registered fl.
- Flush: RAT <= RRAT including this cycle's commits; fl <= rfl including this cycle's frees; issue ignored.
- free_count is the registered popcount of fl.
- No special zero register; the owner of decode suppresses renames for it by deasserting issue.

Decomposition:
- rat_pkg: ARCH_IDX/PRF_IDX defaults, a SEL-style lane slice macro/function, and reset-map constants.
- One sub-module, kth_free_sel: takes the fl vector and issue mask and returns WIDTH one-hot grants plus encoded indices. It is instanced once and is tested standalone.
- RAT/RRAT/free-list storage stays inline.

Test Plan:
- Reset, then WIDTH=2 issue dest r3,r4 -> pdest 32,33; next cycle r3 source reads 32; free_count 30.
- Intra-group: lane0 dest r5, lane1 srcA r5 and dest r5 -> lane1 prega = lane0 pdest, pdest_old = lane0 pdest, RAT[r5] = lane1 pdest.
- Drain: issue until free_count=1 -> rename_ready=0; further issue ignored, RAT unchanged. One commit frees a reg -> rename_ready=1 next cycle.
- Commit r3->32 then r3->34 in the same cycle -> frees 3 and 32, RRAT[r3]=34, rfl[34]=0.
- Flush after 3 speculative renames with 1 same-cycle commit -> RAT equals RRAT post-commit, fl equals rfl, free_count recomputed.
- Assert reset mid-issue, async between edges -> state returns to the reset map immediately, no allocation recorded.
